// File: rtl/cart_rom_loader.sv
// Turns the 16-bit ioctl cartridge download into the byte-wide INIT stream of the cartridge ROM.
// Optional 0xFF padding to a power-of-two image size is enabled by defining CART_ROM_PAD_EN.
module cart_rom_loader #(
    parameter int ADDR_W   = 17,
    parameter int MIN_LOG2 = 13
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              dl_active_i,
    input  logic              dl_wr_i,
    input  logic [24:0]       dl_addr_i,
    input  logic [15:0]       dl_data_i,
    output logic              dl_wait_o,
    output logic              init_sel_o,
    output logic [ADDR_W-1:0] init_addr_o,
    output logic [7:0]        init_data_o,
    output logic              init_valid_o,
    output logic              busy_o,
    output logic              overflow_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_WORD = 3'd2,
        S_LO   = 3'd3,
        S_HI   = 3'd4,
`ifdef CART_ROM_PAD_EN
        S_PAD  = 3'd5,
`endif
        S_END  = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic              dl_wait_q, dl_wait_d;
    logic              init_sel_q, init_sel_d;
    logic [ADDR_W-1:0] init_addr_q, init_addr_d;
    logic [7:0]        init_data_q, init_data_d;
    logic              init_valid_q, init_valid_d;
    logic              busy_q, busy_d;
    logic              overflow_q, overflow_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [15:0]       word_q, word_d;
    logic [ADDR_W-2:0] waddr_q, waddr_d;
    logic              oor_q, oor_d;
    logic              in_range_s;
    logic [ADDR_W:0]   word_end_s;
    logic              unused_addr_bit_s;

    assign unused_addr_bit_s = dl_addr_i[0];
    assign in_range_s = (dl_addr_i[24:ADDR_W] == {(25-ADDR_W){1'b0}});
    // One past the odd byte of the held word; this is the candidate length.
    assign word_end_s = {1'b0, waddr_q, 1'b0} + {{(ADDR_W-1){1'b0}}, 2'd2};

`ifdef CART_ROM_PAD_EN
    localparam logic [ADDR_W-1:0] MIN_MASK = ADDR_W'((64'd1 << MIN_LOG2) - 64'd1);

    logic [ADDR_W-1:0] pad_addr_q, pad_addr_d;
    logic [ADDR_W-1:0] len_m1_s;
    logic [ADDR_W-1:0] pad_last_s;

    function automatic logic [ADDR_W-1:0] smear_right(input logic [ADDR_W-1:0] x);
        logic [ADDR_W-1:0] r;
        r = x;
        for (int i = 0; i < ADDR_W; i++) begin
            r = r | (r >> 1);
        end
        return r;
    endfunction

    // Last padded address is 2**k-1: the all-ones cover of len-1, never below the minimum size.
    assign len_m1_s   = len_q[ADDR_W-1:0] - {{(ADDR_W-1){1'b0}}, 1'b1};
    assign pad_last_s = (len_q == {(ADDR_W+1){1'b0}}) ? MIN_MASK : (smear_right(len_m1_s) | MIN_MASK);
`endif

    // Next-state and next-output logic; outputs are registered from these values.
    always_comb begin
        state_d      = state_q;
        dl_wait_d    = dl_wait_q;
        init_sel_d   = init_sel_q;
        init_addr_d  = init_addr_q;
        init_data_d  = init_data_q;
        init_valid_d = 1'b0;
        overflow_d   = overflow_q;
        len_d        = len_q;
        word_d       = word_q;
        waddr_d      = waddr_q;
        oor_d        = oor_q;
`ifdef CART_ROM_PAD_EN
        pad_addr_d   = pad_addr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (dl_active_i) begin
                    state_d    = S_ARM;
                    init_sel_d = 1'b1;
                    overflow_d = 1'b0;
                    len_d      = {(ADDR_W+1){1'b0}};
                    dl_wait_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARM: begin
                state_d   = S_WORD;
                dl_wait_d = 1'b0;
                if (dl_wr_i) begin
                    overflow_d = 1'b1;
                end else begin
                    overflow_d = overflow_q;
                end
            end
            S_WORD: begin
                if (dl_wr_i) begin
                    state_d   = S_LO;
                    dl_wait_d = 1'b1;
                    word_d    = dl_data_i;
                    waddr_d   = dl_addr_i[ADDR_W-1:1];
                    oor_d     = !in_range_s;
                    if (in_range_s) begin
                        init_valid_d = 1'b1;
                        init_addr_d  = {dl_addr_i[ADDR_W-1:1], 1'b0};
                        init_data_d  = dl_data_i[7:0];
                    end else begin
                        overflow_d = 1'b1;
                    end
                end else if (!dl_active_i) begin
`ifdef CART_ROM_PAD_EN
                    if (len_q <= {1'b0, pad_last_s}) begin
                        state_d      = S_PAD;
                        pad_addr_d   = len_q[ADDR_W-1:0];
                        init_valid_d = 1'b1;
                        init_addr_d  = len_q[ADDR_W-1:0];
                        init_data_d  = 8'hFF;
                    end else begin
                        state_d    = S_END;
                        init_sel_d = 1'b0;
                    end
`else
                    state_d    = S_END;
                    init_sel_d = 1'b0;
`endif
                end else begin
                    state_d = S_WORD;
                end
            end
            S_LO: begin
                state_d = S_HI;
                if (dl_wr_i) begin
                    overflow_d = 1'b1;
                end else begin
                    overflow_d = overflow_q;
                end
                if (!oor_q) begin
                    init_valid_d = 1'b1;
                    init_addr_d  = {waddr_q, 1'b1};
                    init_data_d  = word_q[15:8];
                end else begin
                    init_valid_d = 1'b0;
                end
            end
            S_HI: begin
                state_d   = S_WORD;
                dl_wait_d = 1'b0;
                if (dl_wr_i) begin
                    overflow_d = 1'b1;
                end else begin
                    overflow_d = overflow_q;
                end
                if (!oor_q && (word_end_s > len_q)) begin
                    len_d = word_end_s;
                end else begin
                    len_d = len_q;
                end
            end
`ifdef CART_ROM_PAD_EN
            S_PAD: begin
                if (pad_addr_q == pad_last_s) begin
                    state_d    = S_END;
                    init_sel_d = 1'b0;
                end else begin
                    pad_addr_d   = pad_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    init_valid_d = 1'b1;
                    init_addr_d  = pad_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    init_data_d  = 8'hFF;
                end
            end
`endif
            S_END: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d    = S_IDLE;
                init_sel_d = 1'b0;
                dl_wait_d  = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            dl_wait_q    <= 1'b0;
            init_sel_q   <= 1'b0;
            init_addr_q  <= {ADDR_W{1'b0}};
            init_data_q  <= 8'h00;
            init_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
            len_q        <= {(ADDR_W+1){1'b0}};
            word_q       <= 16'h0000;
            waddr_q      <= {(ADDR_W-1){1'b0}};
            oor_q        <= 1'b0;
`ifdef CART_ROM_PAD_EN
            pad_addr_q   <= {ADDR_W{1'b0}};
`endif
        end else begin
            state_q      <= state_d;
            dl_wait_q    <= dl_wait_d;
            init_sel_q   <= init_sel_d;
            init_addr_q  <= init_addr_d;
            init_data_q  <= init_data_d;
            init_valid_q <= init_valid_d;
            busy_q       <= busy_d;
            overflow_q   <= overflow_d;
            len_q        <= len_d;
            word_q       <= word_d;
            waddr_q      <= waddr_d;
            oor_q        <= oor_d;
`ifdef CART_ROM_PAD_EN
            pad_addr_q   <= pad_addr_d;
`endif
        end
    end

    assign dl_wait_o    = dl_wait_q;
    assign init_sel_o   = init_sel_q;
    assign init_addr_o  = init_addr_q;
    assign init_data_o  = init_data_q;
    assign init_valid_o = init_valid_q;
    assign busy_o       = busy_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_cart_rom_loader.sv
// Scoreboard bench for cart_rom_loader: stimulus pushes expected INIT bytes, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_cart_rom_loader;
    localparam int ADDR_W   = 17;
    localparam int MIN_LOG2 = 13;

    logic              clk = 1'b0;
    logic              reset, dl_active, dl_wr;
    logic [24:0]       dl_addr;
    logic [15:0]       dl_data;
    logic              dl_wait_o, init_sel_o, init_valid_o, busy_o, overflow_o;
    logic [ADDR_W-1:0] init_addr_o;
    logic [7:0]        init_data_o;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [7:0]        d;
    } byte_t;

    byte_t             exp_q[$];
    int                errors = 0;
    int                checks = 0;
    int                model_len;
    logic [ADDR_W-1:0] last_addr = '0;

    always #5 clk = ~clk;

    cart_rom_loader #(.ADDR_W(ADDR_W), .MIN_LOG2(MIN_LOG2)) dut (
        .clk_i(clk), .reset_i(reset), .dl_active_i(dl_active), .dl_wr_i(dl_wr),
        .dl_addr_i(dl_addr), .dl_data_i(dl_data), .dl_wait_o(dl_wait_o),
        .init_sel_o(init_sel_o), .init_addr_o(init_addr_o), .init_data_o(init_data_o),
        .init_valid_o(init_valid_o), .busy_o(busy_o), .overflow_o(overflow_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every INIT write must match the head of the expectation queue.
    always @(negedge clk) begin
        if (init_valid_o) begin
            checks++;
            if (init_sel_o !== 1'b1) begin
                errors++;
                $display("FAIL sel_on_valid: got %0b expected 1", init_sel_o);
            end
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte: got addr 0x%0h data 0x%0h expected none", init_addr_o, init_data_o);
            end else begin
                byte_t e;
                e = exp_q.pop_front();
                if (init_addr_o !== e.a || init_data_o !== e.d) begin
                    errors++;
                    $display("FAIL byte: got 0x%0h/0x%0h expected 0x%0h/0x%0h", init_addr_o, init_data_o, e.a, e.d);
                end
            end
            last_addr = init_addr_o;
        end
    end

    task automatic push_byte(input int a, input logic [7:0] d);
        byte_t b;
        b.a = ADDR_W'(a);
        b.d = d;
        exp_q.push_back(b);
    endtask

    task automatic start_dl();
        model_len = 0;
        dl_active = 1'b1;
        tick();
        chk("arm_sel", {31'd0, init_sel_o}, 32'd1);
        chk("arm_wait", {31'd0, dl_wait_o}, 32'd1);
        chk("arm_ovf", {31'd0, overflow_o}, 32'd0);
        tick();
    endtask

    task automatic wr_word(input int a, input logic [15:0] d, input logic last);
        int t = 0;
        while (dl_wait_o && t < 20) begin
            tick();
            t++;
        end
        if (dl_wait_o) begin
            checks++;
            errors++;
            $display("FAIL wait_timeout: dl_wait still 1 after %0d cycles, required 0", t);
        end
        if (a < (1 << ADDR_W)) begin
            push_byte(a & ~1, d[7:0]);
            push_byte(a | 1, d[15:8]);
            if ((a & ~1) + 2 > model_len) model_len = (a & ~1) + 2;
        end
        dl_addr = 25'(a);
        dl_data = d;
        dl_wr   = 1'b1;
        if (last) dl_active = 1'b0;
        tick();
        dl_wr = 1'b0;
    endtask

    task automatic end_dl();
        int t = 0;
`ifdef CART_ROM_PAD_EN
        int k = MIN_LOG2;
        while ((1 << k) < model_len) k++;
        for (int a = model_len; a < (1 << k); a++) push_byte(a, 8'hFF);
`endif
        dl_active = 1'b0;
        while (busy_o && t < 20000) begin
            tick();
            t++;
        end
        chk("busy_drop", {31'd0, busy_o}, 32'd0);
        chk("sel_drop", {31'd0, init_sel_o}, 32'd0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; dl_active = 1'b0; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
        repeat (3) tick();
        chk("rst_sel", {31'd0, init_sel_o}, 32'd0);
        chk("rst_valid", {31'd0, init_valid_o}, 32'd0);
        chk("rst_wait", {31'd0, dl_wait_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_ovf", {31'd0, overflow_o}, 32'd0);
        reset = 1'b0;
        tick();

        // Two words, then download end.
        start_dl();
        wr_word(0, 16'h2211, 1'b0);
        wr_word(2, 16'h4433, 1'b0);
        end_dl();
        chk("t1_ovf", {31'd0, overflow_o}, 32'd0);

        // Latency and dropped second strobe.
        start_dl();
        push_byte(4, 8'h55);
        push_byte(5, 8'h66);
        model_len = 6;
        dl_addr = 25'd4; dl_data = 16'h6655; dl_wr = 1'b1;
        tick();
        chk("lat_wait_n1", {31'd0, dl_wait_o}, 32'd1);
        chk("lat_valid_n1", {31'd0, init_valid_o}, 32'd1);
        dl_addr = 25'd6; dl_data = 16'hBEEF;
        tick();
        dl_wr = 1'b0;
        chk("lat_wait_n2", {31'd0, dl_wait_o}, 32'd1);
        chk("lat_valid_n2", {31'd0, init_valid_o}, 32'd1);
        tick();
        chk("lat_wait_n3", {31'd0, dl_wait_o}, 32'd0);
        chk("lat_valid_n3", {31'd0, init_valid_o}, 32'd0);
        chk("drop_ovf", {31'd0, overflow_o}, 32'd1);
        end_dl();

        // Out-of-range word: no bytes, overflow set.
        start_dl();
        wr_word(32'h20000, 16'hA5A5, 1'b0);
        chk("oor_ovf", {31'd0, overflow_o}, 32'd1);
        end_dl();

        // Reset during LO aborts; then restart with ARM.
        start_dl();
        push_byte(8, 8'h88);
        dl_addr = 25'd8; dl_data = 16'h7788; dl_wr = 1'b1;
        tick();
        dl_wr = 1'b0;
        chk("lo_valid", {31'd0, init_valid_o}, 32'd1);
        reset = 1'b1; dl_active = 1'b0;
        tick();
        chk("abort_sel", {31'd0, init_sel_o}, 32'd0);
        chk("abort_valid", {31'd0, init_valid_o}, 32'd0);
        chk("abort_wait", {31'd0, dl_wait_o}, 32'd0);
        chk("abort_busy", {31'd0, busy_o}, 32'd0);
        reset = 1'b0;
        repeat (2) tick();
        chk("abort_queue", 32'(exp_q.size()), 32'd0);

        // Restart; DL_ACTIVE drops together with the final strobe.
        start_dl();
        wr_word(16, 16'hCCDD, 1'b1);
        end_dl();

        // 0x2400-byte image.
        start_dl();
        for (int i = 0; i < 'h2400; i += 2) wr_word(i, 16'(i * 3 + 1), 1'b0);
        end_dl();
`ifdef CART_ROM_PAD_EN
        chk("last_addr", {15'd0, last_addr}, 32'h3FFF);
`else
        chk("last_addr", {15'd0, last_addr}, 32'h23FF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
